gpio_ahb_arbiter: RTL and testbench
===================================

Name: gpio_ahb_arbiter

Overview:
Two-requester round-robin arbiter and single-outstanding AHB-Lite master that shares one AHB GPIO slave (17-bit GPIO with parity) between two on-chip clients. It accepts simple read/write commands, sequences the AHB address and data phases, and generates the write parity bit according to the selected parity mode. It returns read data and parity/timeout status tagged with the requester ID. It sits between the clients and the GPIO slave's HSEL/HADDR/HTRANS/HWDATA/HREADYOUT/HRDATA/PARITYERR pins.

Parameters:
BASE_ADDR, 32'h5300_0000, GPIO slave base; HADDR = BASE_ADDR + {24'h0, rN_addr}
TIMEOUT, 16, max data-phase wait cycles with HREADYOUT low before abort (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
r0_valid / r1_valid  in  1  command valid, requester 0 / 1
r0_ready / r1_ready  out  1  command accepted this cycle (valid&ready)
r0_write / r1_write  in  1  1=write, 0=read
r0_addr / r1_addr  in  8  register byte offset
r0_wdata / r1_wdata  in  16  write data (parity generated internally)
cfg_parity_odd  in  1  0=even, 1=odd parity; sampled at acceptance
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  1  requester that owns the response
rsp_rdata  out  17  HRDATA[16:0] for reads, 0 for writes
rsp_parityerr  out  1  PARITYERR sampled at data-phase completion
rsp_timeout  out  1  transfer aborted by timeout
HADDR  out  32  AHB address
HTRANS  out  2  AHB transfer type (00 IDLE, 10 NONSEQ only)
HWRITE  out  1  AHB write
HWDATA  out  32  AHB write data
HSEL  out  1  slave select
HREADY  out  1  HREADY into slave
PARITYSEL  out  1  parity mode to slave
HREADYOUT  in  1  slave ready
HRDATA  in  32  slave read data
PARITYERR  in  1  slave parity error flag

Behaviour:
- Reset (rst_n low at posedge): state IDLE, last_grant=1, every output 0 except HREADY=1; an in-flight transfer is dropped with no rsp_valid.
- FSM IDLE -> ADDR -> DATA -> IDLE.
- IDLE: rN_ready combinational = grant. If one valid, grant it. If both valid, grant the one != last_grant. On acceptance: latch id, write, addr, wdata, cfg_parity_odd; update last_grant; go ADDR. rN_ready is 0 in every other state.
- ADDR (1 cycle): HSEL=1, HTRANS=10, HADDR=BASE_ADDR+addr, HWRITE=write; go DATA.
- DATA: HSEL=0, HTRANS=00, HADDR/HWRITE hold.
  - HWDATA = {15'b0, p, wdata}, where p = ^wdata XOR parity_odd; HWDATA=0 for reads.
  - HREADY = HREADYOUT.
  - Wait counter increments each cycle HREADYOUT=0.
- Completion: at the posedge with HREADYOUT=1, register rsp_valid=1, rsp_id, rsp_rdata (HRDATA[16:0] if read), rsp_parityerr=PARITYERR, rsp_timeout=0; go IDLE.
- Timeout: at the posedge where the wait counter reaches TIMEOUT with HREADYOUT still 0, register rsp_valid=1, rsp_timeout=1, rsp_rdata=0, rsp_parityerr=0; go IDLE. Counter clears on exit from DATA.
- PARITYSEL: registered from the latched cfg_parity_odd at acceptance; stable for the whole transfer.
- Latency, zero wait states: accept at cycle T, address phase T+1, data phase T+2, rsp_valid high in T+3.
  - A new acceptance is allowed in T+3, giving throughput of 1 transfer per 3 cycles.
  - Each slave wait state adds 1 cycle.
- rsp_valid and all rsp_* fields are 0 or hold except in the strobe cycle; rsp_* are cleared to 0 on reset.
- Commands held valid without acceptance must not be lost. The arbiter never grants a requester whose valid is 0.

Test Plan:
- Reset then r0 write addr=0x00 wdata=16'h00FF, even parity, HREADYOUT=1 -> r0_ready at T; T+1 HSEL=1, HTRANS=10, HADDR=0x5300_0000, HWRITE=1; T+2 HWDATA=32'h0000_00FF; T+3 rsp_valid=1, rsp_id=0, rsp_timeout=0.
- Same write with cfg_parity_odd=1, wdata=16'h0001 -> HWDATA=32'h0000_0001, PARITYSEL=1. With even parity, wdata=16'h0001 -> HWDATA=32'h0001_0001.
- r1 read addr=0x04, HRDATA=32'h0001_A5A5, PARITYERR=1, HREADYOUT low for 3 cycles -> rsp_valid at T+6, rsp_id=1, rsp_rdata=17'h1A5A5, rsp_parityerr=1.
- r0 and r1 valid continuously from reset -> grants r0, r1, r0, r1, each 3 cycles apart; rsp_id alternates 0,1,0,1.
- HREADYOUT stuck at 0, TIMEOUT=16 -> rsp_valid with rsp_timeout=1, rsp_rdata=0; FSM returns to IDLE and the next command completes normally.
- rst_n low during DATA phase -> no rsp_valid; next cycle HSEL=0, HTRANS=00, HREADY=1; first post-reset grant goes to r0.

Source files
------------

// File: rtl/gpio_ahb_arbiter.sv
// gpio_ahb_arbiter: two-client round-robin front end and single-outstanding
// AHB-Lite master for a 17-bit GPIO slave with write-parity generation.
module gpio_ahb_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h5300_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic        r0_write,
  input  logic [7:0]  r0_addr,
  input  logic [15:0] r0_wdata,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic        r1_write,
  input  logic [7:0]  r1_addr,
  input  logic [15:0] r1_wdata,
  input  logic        cfg_parity_odd,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [16:0] rsp_rdata,
  output logic        rsp_parityerr,
  output logic        rsp_timeout,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic        HSEL,
  output logic        HREADY,
  output logic        PARITYSEL,
  input  logic        HREADYOUT,
  input  logic [31:0] HRDATA,
  input  logic        PARITYERR
);

  // The wait counter only needs to hold 0..TIMEOUT-1; the abort fires on the
  // low-ready cycle that would take it to TIMEOUT.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             last_grant;
  logic             gnt0, gnt1, accept;
  logic             sel_write;
  logic [7:0]       sel_addr;
  logic [15:0]      sel_wdata;
  logic             cmd_id, cmd_write, cmd_parity_odd;
  logic [15:0]      cmd_wdata;
  logic [CNT_W-1:0] wait_cnt;
  logic             done, expire;
  logic [14:0]      unused_hrdata;

  // Parity bit placed above the 16 data bits: even parity unless odd is set.
  function automatic logic wr_parity(input logic [15:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  assign unused_hrdata = HRDATA[31:17];

  assign r0_ready  = gnt0;
  assign r1_ready  = gnt1;
  assign accept    = gnt0 | gnt1;
  assign sel_write = gnt1 ? r1_write : r0_write;
  assign sel_addr  = gnt1 ? r1_addr  : r0_addr;
  assign sel_wdata = gnt1 ? r1_wdata : r0_wdata;

  assign done   = (state == DATA) && HREADYOUT;
  assign expire = (state == DATA) && !HREADYOUT && (wait_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration, next state and AHB phase outputs.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    HSEL      = 1'b0;
    HTRANS    = 2'b00;
    HREADY    = 1'b1;
    HWDATA    = '0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (r0_valid && r1_valid) begin
            gnt0 = last_grant;
            gnt1 = !last_grant;
          end else begin
            gnt0 = r0_valid;
            gnt1 = r1_valid;
          end
        end
        if (gnt0 || gnt1) state_nxt = ADDR;
      end
      ADDR: begin
        HSEL      = 1'b1;
        HTRANS    = 2'b10;
        state_nxt = DATA;
      end
      DATA: begin
        HREADY = HREADYOUT;
        if (cmd_write)
          HWDATA = {15'h0, wr_parity(cmd_wdata, cmd_parity_odd), cmd_wdata};
        if (done || expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture at acceptance; address, direction and parity mode hold
  // on the bus until the next acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant     <= 1'b1;
      cmd_id         <= 1'b0;
      cmd_write      <= 1'b0;
      cmd_wdata      <= '0;
      cmd_parity_odd <= 1'b0;
      HADDR          <= '0;
      HWRITE         <= 1'b0;
      PARITYSEL      <= 1'b0;
    end else if (accept) begin
      last_grant     <= gnt1;
      cmd_id         <= gnt1;
      cmd_write      <= sel_write;
      cmd_wdata      <= sel_wdata;
      cmd_parity_odd <= cfg_parity_odd;
      HADDR          <= BASE_ADDR + {24'h0, sel_addr};
      HWRITE         <= sel_write;
      PARITYSEL      <= cfg_parity_odd;
    end
  end

  // Data-phase wait counter; cleared whenever the data phase is left.
  always_ff @(posedge clk) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if ((state == DATA) && !HREADYOUT && !expire)
      wait_cnt <= wait_cnt + CNT_W'(1);
    else
      wait_cnt <= '0;
  end

  // Response strobe; fields hold their last value between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_rdata     <= '0;
      rsp_parityerr <= 1'b0;
      rsp_timeout   <= 1'b0;
    end else begin
      rsp_valid <= done || expire;
      if (done) begin
        rsp_id        <= cmd_id;
        rsp_rdata     <= cmd_write ? 17'h0 : HRDATA[16:0];
        rsp_parityerr <= PARITYERR;
        rsp_timeout   <= 1'b0;
      end else if (expire) begin
        rsp_id        <= cmd_id;
        rsp_rdata     <= '0;
        rsp_parityerr <= 1'b0;
        rsp_timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpio_ahb_arbiter.sv
// Testbench for gpio_ahb_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_gpio_ahb_arbiter;

  localparam logic [31:0] BASE = 32'h5300_0000;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r0_write;
  logic [7:0]  r0_addr;
  logic [15:0] r0_wdata;
  logic        r1_valid, r1_ready, r1_write;
  logic [7:0]  r1_addr;
  logic [15:0] r1_wdata;
  logic        cfg_parity_odd;
  logic        rsp_valid, rsp_id, rsp_parityerr, rsp_timeout;
  logic [16:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HSEL, HREADY, PARITYSEL, HREADYOUT, PARITYERR;

  int total = 0;
  int bad   = 0;

  gpio_ahb_arbiter #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_write(r0_write),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_write(r1_write),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .cfg_parity_odd(cfg_parity_odd),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .rsp_parityerr(rsp_parityerr), .rsp_timeout(rsp_timeout),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HSEL(HSEL), .HREADY(HREADY), .PARITYSEL(PARITYSEL),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .PARITYERR(PARITYERR)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    r0_valid = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
    cfg_parity_odd = 1'b0;
    HREADYOUT = 1'b1; HRDATA = '0; PARITYERR = 1'b0;
  endtask

  task automatic apply_reset();
    tick();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    HRDATA = 32'hFFFF_FFFF;
    PARITYERR = 1'b1;
    apply_reset();
    mid();
    total++;
    if ({r0_ready, r1_ready, rsp_valid} !== 3'b000) begin
      bad++; $display("FAIL reset_hs got=%b exp=000", {r0_ready, r1_ready, rsp_valid});
    end
    total++;
    if ({rsp_id, rsp_rdata, rsp_parityerr, rsp_timeout} !== 20'h0) begin
      bad++; $display("FAIL reset_rsp got=%h exp=0", {rsp_id, rsp_rdata, rsp_parityerr, rsp_timeout});
    end
    total++;
    if ({HADDR, HTRANS, HWRITE, HWDATA, HSEL, PARITYSEL} !== 69'h0) begin
      bad++; $display("FAIL reset_ahb got=%h exp=0", {HADDR, HTRANS, HWRITE, HWDATA, HSEL, PARITYSEL});
    end
    total++;
    if (HREADY !== 1'b1) begin
      bad++; $display("FAIL reset_hready got=%b exp=1", HREADY);
    end
    tick();
  endtask

  logic [15:0] wp_data [3] = '{16'h00FF, 16'h0001, 16'h0001};
  logic        wp_odd  [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] wp_exp  [3] = '{32'h0000_00FF, 32'h0000_0001, 32'h0001_0001};

  task automatic test_write_parity();
    for (int i = 0; i < 3; i++) begin
      r0_valid = 1'b1; r0_write = 1'b1; r0_addr = 8'h00; r0_wdata = wp_data[i];
      cfg_parity_odd = wp_odd[i]; HREADYOUT = 1'b1;
      mid();
      total++;
      if ({r0_ready, r1_ready, rsp_valid} !== 3'b100) begin
        bad++; $display("FAIL wr_accept[%0d] got=%b exp=100", i, {r0_ready, r1_ready, rsp_valid});
      end
      tick();
      r0_valid = 1'b0; cfg_parity_odd = !wp_odd[i];
      mid();
      total++;
      if ({HSEL, HTRANS, HWRITE, HADDR, PARITYSEL} !== {1'b1, 2'b10, 1'b1, BASE, wp_odd[i]}) begin
        bad++; $display("FAIL wr_addr[%0d] got=%h exp=%h", i, {HSEL, HTRANS, HWRITE, HADDR, PARITYSEL},
                        {1'b1, 2'b10, 1'b1, BASE, wp_odd[i]});
      end
      tick();
      mid();
      total++;
      if ({HSEL, HTRANS, HWDATA, PARITYSEL, rsp_valid} !== {3'b000, wp_exp[i], wp_odd[i], 1'b0}) begin
        bad++; $display("FAIL wr_data[%0d] got=%h exp=%h", i, {HSEL, HTRANS, HWDATA, PARITYSEL, rsp_valid},
                        {3'b000, wp_exp[i], wp_odd[i], 1'b0});
      end
      tick();
      mid();
      total++;
      if ({rsp_valid, rsp_id, rsp_timeout, rsp_rdata} !== {3'b100, 17'h0}) begin
        bad++; $display("FAIL wr_rsp[%0d] got=%h exp=%h", i, {rsp_valid, rsp_id, rsp_timeout, rsp_rdata},
                        {3'b100, 17'h0});
      end
      tick();
    end
  endtask

  task automatic test_read_wait();
    r1_valid = 1'b1; r1_write = 1'b0; r1_addr = 8'h04;
    HRDATA = 32'h0001_A5A5; PARITYERR = 1'b1; HREADYOUT = 1'b1;
    mid();
    total++;
    if ({r0_ready, r1_ready} !== 2'b01) begin
      bad++; $display("FAIL rd_accept got=%b exp=01", {r0_ready, r1_ready});
    end
    tick();
    r1_valid = 1'b0;
    mid();
    total++;
    if ({HSEL, HWRITE, HADDR} !== {2'b10, BASE + 32'h4}) begin
      bad++; $display("FAIL rd_addr got=%h exp=%h", {HSEL, HWRITE, HADDR}, {2'b10, BASE + 32'h4});
    end
    for (int k = 2; k <= 5; k++) begin
      tick();
      HREADYOUT = (k == 5);
      mid();
      total++;
      if ({rsp_valid, HREADY, HWDATA} !== {1'b0, (k == 5), 32'h0}) begin
        bad++; $display("FAIL rd_wait[%0d] got=%h exp=%h", k, {rsp_valid, HREADY, HWDATA},
                        {1'b0, (k == 5), 32'h0});
      end
    end
    tick();
    PARITYERR = 1'b0;
    mid();
    total++;
    if ({rsp_valid, rsp_id, rsp_rdata, rsp_parityerr, rsp_timeout} !== {2'b11, 17'h1A5A5, 2'b10}) begin
      bad++; $display("FAIL rd_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_rdata, rsp_parityerr, rsp_timeout},
                      {2'b11, 17'h1A5A5, 2'b10});
    end
    tick();
  endtask

  task automatic test_round_robin();
    bit e0, e1, erv, eid;
    apply_reset();
    r0_valid = 1'b1; r0_write = 1'b1; r0_addr = 8'h10; r0_wdata = 16'h1111;
    r1_valid = 1'b1; r1_write = 1'b1; r1_addr = 8'h14; r1_wdata = 16'h2222;
    for (int k = 0; k < 15; k++) begin
      e0  = (k % 3 == 0) && ((k / 3) % 2 == 0);
      e1  = (k % 3 == 0) && ((k / 3) % 2 == 1);
      erv = (k % 3 == 0) && (k > 0);
      eid = (k > 0) && (((k / 3) - 1) % 2 == 1);
      mid();
      total++;
      if ({r0_ready, r1_ready, rsp_valid} !== {e0, e1, erv}) begin
        bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, {r0_ready, r1_ready, rsp_valid}, {e0, e1, erv});
      end
      if (erv) begin
        total++;
        if (rsp_id !== eid) begin
          bad++; $display("FAIL rr_id[%0d] got=%b exp=%b", k, rsp_id, eid);
        end
      end
      tick();
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  task automatic test_timeout();
    int w, due;
    for (int pass = 0; pass < 2; pass++) begin
      w   = (pass == 1) ? TMO : TMO - 1;
      due = (pass == 1) ? 2 + TMO : 3 + w;
      apply_reset();
      r0_valid = 1'b1; r0_write = 1'b0; r0_addr = 8'h08;
      HRDATA = 32'h0001_FFFF; PARITYERR = 1'b1;
      mid();
      total++;
      if (r0_ready !== 1'b1) begin
        bad++; $display("FAIL to_accept[%0d] got=%b exp=1", pass, r0_ready);
      end
      tick();
      r0_valid = 1'b0;
      for (int k = 1; k <= due; k++) begin
        HREADYOUT = !(k >= 2 && k < 2 + w);
        mid();
        total++;
        if (rsp_valid !== (k == due)) begin
          bad++; $display("FAIL to_strobe[%0d] k=%0d got=%b exp=%b", pass, k, rsp_valid, (k == due));
        end
        if (k == due) begin
          total++;
          if ({rsp_timeout, rsp_parityerr, rsp_rdata} !==
              ((pass == 1) ? {2'b10, 17'h0} : {2'b01, 17'h1FFFF})) begin
            bad++; $display("FAIL to_rsp[%0d] got=%h exp=%h", pass, {rsp_timeout, rsp_parityerr, rsp_rdata},
                            (pass == 1) ? {2'b10, 17'h0} : {2'b01, 17'h1FFFF});
          end
        end
        tick();
      end
    end
    HREADYOUT = 1'b1; PARITYERR = 1'b0;
    r1_valid = 1'b1; r1_write = 1'b1; r1_addr = 8'h0C; r1_wdata = 16'h1234;
    mid();
    total++;
    if (r1_ready !== 1'b1) begin
      bad++; $display("FAIL to_recover_accept got=%b exp=1", r1_ready);
    end
    tick();
    r1_valid = 1'b0;
    tick();
    tick();
    mid();
    total++;
    if ({rsp_valid, rsp_id, rsp_timeout} !== 3'b110) begin
      bad++; $display("FAIL to_recover_rsp got=%b exp=110", {rsp_valid, rsp_id, rsp_timeout});
    end
    tick();
  endtask

  task automatic test_reset_in_data();
    apply_reset();
    r0_valid = 1'b1; r0_write = 1'b1; r0_addr = 8'h20; r0_wdata = 16'hBEEF; cfg_parity_odd = 1'b1;
    mid();
    total++;
    if (r0_ready !== 1'b1) begin
      bad++; $display("FAIL rid_accept got=%b exp=1", r0_ready);
    end
    tick();
    r0_valid = 1'b0; HREADYOUT = 1'b0;
    tick();
    rst_n = 1'b0;
    HREADYOUT = 1'b1;
    tick();
    rst_n = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1; cfg_parity_odd = 1'b0;
    mid();
    total++;
    if ({rsp_valid, HSEL, HTRANS, HREADY, HADDR, PARITYSEL} !== {4'b0000, 1'b1, 32'h0, 1'b0}) begin
      bad++; $display("FAIL rid_state got=%h exp=%h", {rsp_valid, HSEL, HTRANS, HREADY, HADDR, PARITYSEL},
                      {4'b0000, 1'b1, 32'h0, 1'b0});
    end
    total++;
    if ({r0_ready, r1_ready} !== 2'b10) begin
      bad++; $display("FAIL rid_grant got=%b exp=10", {r0_ready, r1_ready});
    end
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    mid();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rid_nostrobe got=%b exp=0", rsp_valid);
    end
    tick();
  endtask

  task automatic test_random();
    int  acc_c, rsp_c, w;
    bit  have, is_to, last, g, e0, e1, in_data, e_hsel, e_hready;
    bit  pend [2];
    int  gap  [2];
    logic        pw [2];
    logic [7:0]  pa [2];
    logic [15:0] pd [2];
    logic        cw, codd, cid;
    logic [15:0] cd;
    logic [31:0] e_haddr, e_hwdata;
    logic [1:0]  e_htrans;
    logic        e_hwrite, e_psel, e_perr;
    logic [16:0] e_rdata;
    apply_reset();
    have = 0; is_to = 0; last = 1; acc_c = 0; rsp_c = 0; w = 0;
    e_haddr = '0; e_hwrite = 1'b0; e_psel = 1'b0; e_rdata = '0; e_perr = 1'b0;
    cw = 1'b0; codd = 1'b0; cid = 1'b0; cd = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; gap[i] = i; pw[i] = 1'b0; pa[i] = '0; pd[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          if (gap[i] == 0) begin
            pend[i] = 1;
            pw[i] = ($urandom_range(0, 1) == 1);
            pa[i] = 8'($urandom);
            pd[i] = 16'($urandom);
          end else begin
            gap[i]--;
          end
        end
      end
      r0_valid = pend[0]; r0_write = pw[0]; r0_addr = pa[0]; r0_wdata = pd[0];
      r1_valid = pend[1]; r1_write = pw[1]; r1_addr = pa[1]; r1_wdata = pd[1];
      cfg_parity_odd = ($urandom_range(0, 1) == 1);
      HRDATA = $urandom;
      PARITYERR = ($urandom_range(0, 1) == 1);
      in_data = have && (c >= acc_c + 2) && (c < rsp_c);
      if (in_data) HREADYOUT = !is_to && (c - acc_c - 2 == w);
      else         HREADYOUT = ($urandom_range(0, 1) == 1);
      if (in_data && HREADYOUT) begin
        e_rdata = cw ? 17'h0 : HRDATA[16:0];
        e_perr  = PARITYERR;
      end
      mid();
      e0 = 0; e1 = 0;
      if (!have || c >= rsp_c) begin
        if (pend[0] && pend[1]) begin e0 = last; e1 = !last; end
        else begin e0 = pend[0]; e1 = pend[1]; end
      end
      total++;
      if ({r0_ready, r1_ready} !== {e0, e1}) begin
        bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, {r0_ready, r1_ready}, {e0, e1});
      end
      e_hsel   = have && (c == acc_c + 1);
      e_htrans = e_hsel ? 2'b10 : 2'b00;
      e_hwdata = (in_data && cw) ? {15'h0, (^cd) ^ codd, cd} : 32'h0;
      e_hready = in_data ? HREADYOUT : 1'b1;
      total++;
      if ({HSEL, HTRANS, HWRITE, HADDR, HWDATA, HREADY, PARITYSEL} !==
          {e_hsel, e_htrans, e_hwrite, e_haddr, e_hwdata, e_hready, e_psel}) begin
        bad++; $display("FAIL rnd_ahb c=%0d got=%h exp=%h", c,
                        {HSEL, HTRANS, HWRITE, HADDR, HWDATA, HREADY, PARITYSEL},
                        {e_hsel, e_htrans, e_hwrite, e_haddr, e_hwdata, e_hready, e_psel});
      end
      total++;
      if (rsp_valid !== (have && c == rsp_c)) begin
        bad++; $display("FAIL rnd_strobe c=%0d got=%b exp=%b", c, rsp_valid, (have && c == rsp_c));
      end
      if (have && c == rsp_c) begin
        total++;
        if ({rsp_id, rsp_timeout, rsp_parityerr, rsp_rdata} !== {cid, is_to, e_perr, e_rdata}) begin
          bad++; $display("FAIL rnd_rsp c=%0d got=%h exp=%h", c, {rsp_id, rsp_timeout, rsp_parityerr, rsp_rdata},
                          {cid, is_to, e_perr, e_rdata});
        end
      end
      if (e0 || e1) begin
        g = e1;
        cid = g; cw = pw[g]; cd = pd[g]; codd = cfg_parity_odd;
        last = g;
        e_haddr = BASE + {24'h0, pa[g]};
        e_hwrite = pw[g];
        e_psel = cfg_parity_odd;
        if ($urandom_range(0, 7) == 0) w = int'($urandom_range(TMO - 1, TMO + 2));
        else                           w = int'($urandom_range(0, 3));
        is_to = (w >= TMO);
        rsp_c = is_to ? c + 2 + TMO : c + 3 + w;
        acc_c = c;
        have = 1;
        if (is_to) begin e_rdata = '0; e_perr = 1'b0; end
        pend[g] = 0;
        gap[g] = int'($urandom_range(0, 3));
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    test_reset();
    test_write_parity();
    test_read_wait();
    test_round_robin();
    test_timeout();
    test_reset_in_data();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
